// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles everything that crosses the fetch stage boundary:
//   - controller strobes in: br_taken, taddr, enable_updatePC, enable_fetch
//   - instruction memory: imem_rdy / imem_data in, instrmem_rd / imem_addr out
//   - decode side out: instr_out, instr_pc, instr_valid
//   - program counter view out: pc, npc
//   The slave modport is the fetch unit itself. The master modport is the
//   environment that drives the controller and memory inputs.
interface fetch_unit_if;
   logic        br_taken;
   logic [15:0] taddr;
   logic        enable_updatePC;
   logic        enable_fetch;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic [15:0] pc;
   logic [15:0] npc;
   logic        instrmem_rd;
   logic [15:0] imem_addr;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;

   modport slave (
      input  br_taken, taddr, enable_updatePC, enable_fetch, imem_rdy, imem_data,
      output pc, npc, instrmem_rd, imem_addr, instr_out, instr_pc, instr_valid
   );

   modport master (
      output br_taken, taddr, enable_updatePC, enable_fetch, imem_rdy, imem_data,
      input  pc, npc, instrmem_rd, imem_addr, instr_out, instr_pc, instr_valid
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the program counter, issues one read at a
//   time to instruction memory (held until imem_rdy), and hands each fetched
//   word together with its address to decode as a one-cycle pulse.
//
// Ports
//   clk    : single clock, all state changes on its rising edge
//   reset  : synchronous, active-high; overrides every other input
//   bus    : fetch_unit_if.slave (controller strobes, memory handshake,
//            decode outputs, pc/npc)
//
// Parameters
//   RESET_PC : program counter value loaded by reset
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h3000
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.slave  bus
);

   // IDLE : no read outstanding
   // WAIT : read outstanding, its data will be delivered
   // DROP : read outstanding but squashed by a redirect; wait it out
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t      state_reg;
   logic [15:0] pc_reg;
   logic [15:0] fetch_addr_reg;
   logic [15:0] instr_out_reg;
   logic [15:0] instr_pc_reg;
   logic        instr_valid_reg;
   logic        rd_reg;

   logic [15:0] npc_next;
   logic        redirect;

   assign npc_next = pc_reg + 16'd1;   // wraps 16'hFFFF -> 16'h0000
   assign redirect = bus.enable_updatePC & bus.br_taken;

   // Single state machine with all outputs registered. rd_reg is written
   // alongside every state transition so it always equals (state != IDLE).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         pc_reg          <= RESET_PC;
         fetch_addr_reg  <= RESET_PC;
         instr_out_reg   <= 16'h0000;
         instr_pc_reg    <= 16'h0000;
         instr_valid_reg <= 1'b0;
         rd_reg          <= 1'b0;
      end else begin
         // Program counter: independent of the fetch state.
         if (bus.enable_updatePC) begin
            pc_reg <= bus.br_taken ? bus.taddr : npc_next;
         end

         instr_valid_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               // A late imem_rdy here (e.g. after reset) is ignored.
               // fetch_addr takes the pre-update pc.
               if (bus.enable_fetch) begin
                  fetch_addr_reg <= pc_reg;
                  state_reg      <= ST_WAIT;
                  rd_reg         <= 1'b1;
               end
            end

            ST_WAIT: begin
               if (bus.imem_rdy) begin
                  // A redirect on the completing cycle squashes the data but
                  // does not stop a back-to-back follow-on fetch.
                  if (!redirect) begin
                     instr_out_reg   <= bus.imem_data;
                     instr_pc_reg    <= fetch_addr_reg;
                     instr_valid_reg <= 1'b1;
                  end
                  if (bus.enable_fetch) begin
                     // address switches on the same edge that takes the data,
                     // keeping one instruction per cycle possible
                     fetch_addr_reg <= pc_reg;
                     state_reg      <= ST_WAIT;
                     rd_reg         <= 1'b1;
                  end else begin
                     state_reg <= ST_IDLE;
                     rd_reg    <= 1'b0;
                  end
               end else if (redirect) begin
                  // The memory still owes us this read; keep the request up
                  // but forget the data when it arrives.
                  state_reg <= ST_DROP;
                  rd_reg    <= 1'b1;
               end
            end

            ST_DROP: begin
               if (bus.imem_rdy) begin
                  state_reg <= ST_IDLE;
                  rd_reg    <= 1'b0;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               rd_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = pc_reg;
   assign bus.npc         = npc_next;
   assign bus.instrmem_rd = rd_reg;
   assign bus.imem_addr   = fetch_addr_reg;
   assign bus.instr_out   = instr_out_reg;
   assign bus.instr_pc    = instr_pc_reg;
   assign bus.instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam logic [15:0] RST_PC = 16'h3000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The unit is viewed as "at most one outstanding request", each request
   // carrying its address and whether a redirect has cancelled it.
   logic [15:0] m_pc, m_addr, m_out, m_ipc;
   bit          m_active, m_squashed, m_valid;

   always @(posedge clk) begin
      if (reset) begin
         m_pc = RST_PC; m_addr = RST_PC; m_out = 16'h0; m_ipc = 16'h0;
         m_active = 0; m_squashed = 0; m_valid = 0;
      end else begin
         bit redir;
         redir   = bus.enable_updatePC && bus.br_taken;
         m_valid = 0;
         if (!m_active) begin
            if (bus.enable_fetch) begin
               m_active = 1; m_squashed = 0; m_addr = m_pc;
            end
         end else if (bus.imem_rdy) begin
            if (m_squashed) begin
               m_active = 0;
            end else begin
               if (!redir) begin
                  m_valid = 1; m_out = bus.imem_data; m_ipc = m_addr;
               end
               if (bus.enable_fetch) m_addr = m_pc;
               else m_active = 0;
            end
         end else if (redir) begin
            m_squashed = 1;
         end
         if (bus.enable_updatePC) m_pc = bus.br_taken ? bus.taddr : m_pc + 16'd1;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (checking) begin
         chk("pc",          bus.pc,          m_pc);
         chk("npc",         bus.npc,         m_pc + 16'd1);
         chk("instrmem_rd", {15'd0, bus.instrmem_rd}, {15'd0, m_active});
         chk("imem_addr",   bus.imem_addr,   m_addr);
         chk("instr_valid", {15'd0, bus.instr_valid}, {15'd0, m_valid});
         chk("instr_out",   bus.instr_out,   m_out);
         chk("instr_pc",    bus.instr_pc,    m_ipc);
      end
   end

   // inputs changed after this returns are sampled on the next rising edge
   task automatic next();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.br_taken = 0; bus.taddr = 16'h0; bus.enable_updatePC = 0;
      bus.enable_fetch = 0; bus.imem_rdy = 0; bus.imem_data = 16'h0;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      next();
      checking = 1;
      reset = 0;

      // reset state, idle
      repeat (3) begin
         next();
         chk("lit_rst_pc",  bus.pc,  16'h3000);
         chk("lit_rst_npc", bus.npc, 16'h3001);
         chk("lit_rst_rd",  {15'd0, bus.instrmem_rd}, 16'h0);
         chk("lit_rst_vld", {15'd0, bus.instr_valid}, 16'h0);
      end

      // single fetch, rdy on the second WAIT cycle
      bus.enable_fetch = 1;
      next();
      chk("lit_f_rd1",   {15'd0, bus.instrmem_rd}, 16'h1);
      chk("lit_f_addr",  bus.imem_addr, 16'h3000);
      bus.enable_fetch = 0;
      next();
      chk("lit_f_rd2",   {15'd0, bus.instrmem_rd}, 16'h1);
      bus.imem_rdy = 1; bus.imem_data = 16'h1234;
      next();
      chk("lit_f_vld",   {15'd0, bus.instr_valid}, 16'h1);
      chk("lit_f_out",   bus.instr_out, 16'h1234);
      chk("lit_f_ipc",   bus.instr_pc,  16'h3000);
      chk("lit_f_rd3",   {15'd0, bus.instrmem_rd}, 16'h0);
      bus.imem_rdy = 0;
      next();
      chk("lit_f_vld0",  {15'd0, bus.instr_valid}, 16'h0);
      chk("lit_f_hold",  bus.instr_out, 16'h1234);

      // streaming: one instruction per cycle
      bus.enable_fetch = 1; bus.enable_updatePC = 1; bus.imem_rdy = 1;
      for (int k = 0; k < 6; k++) begin
         bus.imem_data = 16'hA000 + 16'(k);
         next();
         chk("lit_s_rd", {15'd0, bus.instrmem_rd}, 16'h1);
         if (k >= 1) begin
            chk("lit_s_vld", {15'd0, bus.instr_valid}, 16'h1);
            chk("lit_s_out", bus.instr_out, 16'hA000 + 16'(k));
            chk("lit_s_ipc", bus.instr_pc,  16'h3000 + 16'(k - 1));
         end
      end
      bus.enable_fetch = 0; bus.enable_updatePC = 0; bus.imem_data = 16'hBEEF;
      next();
      chk("lit_s_last", bus.instr_pc, 16'h3005);
      bus.imem_rdy = 0;
      next();
      chk("lit_s_idle", {15'd0, bus.instrmem_rd}, 16'h0);

      // redirect while waiting -> DROP, no delivery
      bus.enable_fetch = 1;
      next();
      bus.enable_fetch = 0;
      bus.enable_updatePC = 1; bus.br_taken = 1; bus.taddr = 16'h4000;
      next();
      chk("lit_r_rd",  {15'd0, bus.instrmem_rd}, 16'h1);
      chk("lit_r_pc",  bus.pc, 16'h4000);
      bus.enable_updatePC = 0; bus.br_taken = 0;
      next();
      bus.imem_rdy = 1; bus.imem_data = 16'hDEAD;
      next();
      chk("lit_r_vld", {15'd0, bus.instr_valid}, 16'h0);
      chk("lit_r_rd0", {15'd0, bus.instrmem_rd}, 16'h0);
      bus.imem_rdy = 0; bus.enable_fetch = 1;
      next();
      chk("lit_r_addr", bus.imem_addr, 16'h4000);
      bus.enable_fetch = 0; bus.imem_rdy = 1; bus.imem_data = 16'h5555;
      next();
      chk("lit_r_ipc", bus.instr_pc, 16'h4000);
      bus.imem_rdy = 0;

      // pc wrap
      bus.enable_updatePC = 1; bus.br_taken = 1; bus.taddr = 16'hFFFF;
      next();
      chk("lit_w_pc1", bus.pc, 16'hFFFF);
      bus.br_taken = 0;
      next();
      chk("lit_w_pc",  bus.pc,  16'h0000);
      chk("lit_w_npc", bus.npc, 16'h0001);
      bus.enable_updatePC = 0;

      // reset while waiting, late rdy ignored
      bus.enable_fetch = 1;
      next();
      bus.enable_fetch = 0;
      chk("lit_x_rd1", {15'd0, bus.instrmem_rd}, 16'h1);
      reset = 1;
      next();
      reset = 0;
      chk("lit_x_rd0", {15'd0, bus.instrmem_rd}, 16'h0);
      bus.imem_rdy = 1; bus.imem_data = 16'h7777;
      next();
      chk("lit_x_vld", {15'd0, bus.instr_valid}, 16'h0);
      chk("lit_x_rd",  {15'd0, bus.instrmem_rd}, 16'h0);
      chk("lit_x_pc",  bus.pc, 16'h3000);
      bus.imem_rdy = 0;

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset               = ($urandom_range(0, 99) == 0);
         bus.enable_fetch    = ($urandom_range(0, 1) == 1);
         bus.enable_updatePC = ($urandom_range(0, 2) == 0);
         bus.br_taken        = ($urandom_range(0, 1) == 1);
         bus.taddr           = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         bus.imem_rdy        = ($urandom_range(0, 2) != 0);
         bus.imem_data       = 16'($urandom);
         next();
      end
      reset = 0;
      clear_inputs();
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
